// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//   Arbitrates two requesters onto one shared, externally implemented ALU.
//   One operation is in flight at a time: IDLE (accept) -> EXEC (ALU settles
//   on the registered operands) -> RESP (result held for the owner).
//
// Package package_project_typedefs supplies AluControl, the 4-bit ALU opcode.
//
// Parameters
//   RR_EN        1 = round-robin between the requesters, 0 = port 0 always wins
// Ports
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   reqN_valid   requester N has an operation          (in)
//   reqN_ready   operation of requester N accepted     (out)
//   reqN_op      opcode of requester N                 (in, AluControl)
//   reqN_a/b     32-bit signed operands of requester N (in)
//   rspN_valid   result available for requester N      (out)
//   rspN_ready   requester N takes the result          (in)
//   rspN_result  shared result register                (out, 32)
//   alu_op_o     opcode to the shared ALU              (out, AluControl)
//   alu_a_o/b_o  operands to the shared ALU            (out, 32)
//   alu_result_i combinational result from the ALU     (in, 32)
//   busy_o       high whenever the FSM is not idle     (out)
// ---------------------------------------------------------------------------
package package_project_typedefs;
  typedef enum logic [3:0] {
    ALU_ADD = 4'h0,
    ALU_SUB = 4'h1,
    ALU_AND = 4'h2,
    ALU_OR  = 4'h3,
    ALU_XOR = 4'h4,
    ALU_SLT = 4'h5,
    ALU_SLL = 4'h6,
    ALU_SRL = 4'h7
  } AluControl;
endpackage

module alu_arbiter
  import package_project_typedefs::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  AluControl   req0_op,
  input  AluControl   req1_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req1_a,
  input  logic [31:0] req0_b,
  input  logic [31:0] req1_b,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  input  logic        rsp0_ready,
  input  logic        rsp1_ready,
  output logic [31:0] rsp0_result,
  output logic [31:0] rsp1_result,
  output AluControl   alu_op_o,
  output logic [31:0] alu_a_o,
  output logic [31:0] alu_b_o,
  input  logic [31:0] alu_result_i,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        owner_q, owner_d;
  AluControl   op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] result_q, result_d;

  logic grant;
  logic accept;
  logic owner_ready;

  // Grant selection. With a single valid the grant follows it; under
  // contention round-robin picks the port that did not win last time.
  // Ready is gated by rst_n so nothing looks accepted while reset is held.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = RR_EN ? ~last_grant_q : 1'b0;
    end else begin
      grant = req1_valid;
    end
    accept     = (state_q == IDLE) && (req0_valid || req1_valid);
    req0_ready = accept && !grant && rst_n;
    req1_ready = accept &&  grant && rst_n;
  end

  // Only the owning requester's rsp_ready can retire the response.
  always_comb begin
    owner_ready = owner_q ? rsp1_ready : rsp0_ready;
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    result_d     = result_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d      = EXEC;
          last_grant_d = grant;
          owner_d      = grant;
          op_d         = grant ? req1_op : req0_op;
          a_d          = grant ? req1_a  : req0_a;
          b_d          = grant ? req1_b  : req0_b;
        end
      end
      EXEC: begin
        result_d = alu_result_i;
        state_d  = RESP;
      end
      RESP: begin
        if (owner_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; last_grant resets to 1 so port 0 wins
  // the first contention under round-robin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      op_q         <= ALU_ADD;
      a_q          <= 32'd0;
      b_q          <= 32'd0;
      result_q     <= 32'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      result_q     <= result_d;
    end
  end

  // Outputs come straight from registers, so the ALU inputs stay stable
  // from one accept to the next.
  always_comb begin
    rsp0_valid  = (state_q == RESP) && !owner_q;
    rsp1_valid  = (state_q == RESP) &&  owner_q;
    rsp0_result = result_q;
    rsp1_result = result_q;
    alu_op_o    = op_q;
    alu_a_o     = a_q;
    alu_b_o     = b_q;
    busy_o      = (state_q != IDLE);
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//   Drives one round-robin and one fixed-priority alu_arbiter from the same
//   stimulus. Each instance gets its own behavioural ALU. A scoreboard on the
//   round-robin instance queues the expected result at every accept and
//   compares it when the owner takes the response; a table of single
//   requests and hand-written sequences check timing and corner cases.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_alu_arbiter;
  import package_project_typedefs::*;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  AluControl   req0_op, req1_op;
  logic [31:0] req0_a, req1_a, req0_b, req1_b;
  logic        rsp0_ready, rsp1_ready;

  logic        rr_req0_ready, rr_req1_ready, rr_rsp0_valid, rr_rsp1_valid, rr_busy;
  logic [31:0] rr_rsp0_result, rr_rsp1_result, rr_alu_a, rr_alu_b, rr_alu_result;
  AluControl   rr_alu_op;

  logic        fp_req0_ready, fp_req1_ready, fp_rsp0_valid, fp_rsp1_valid, fp_busy;
  logic [31:0] fp_rsp0_result, fp_rsp1_result, fp_alu_a, fp_alu_b, fp_alu_result;
  AluControl   fp_alu_op;

  int checks;
  int errors;

  typedef struct {
    logic        port;
    logic [31:0] result;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic        port;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_result;
  } vec_t;
  vec_t vecs[9];

  // Behavioural stand-in for the shared ALU; undefined opcodes give a marker.
  function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    case (op)
      4'h0:    return a + b;
      4'h1:    return a - b;
      4'h2:    return a & b;
      4'h3:    return a | b;
      4'h4:    return a ^ b;
      4'h5:    return {31'd0, ($signed(a) < $signed(b))};
      4'h6:    return a << b[4:0];
      4'h7:    return a >> b[4:0];
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign rr_alu_result = alu_model(rr_alu_op, rr_alu_a, rr_alu_b);
  assign fp_alu_result = alu_model(fp_alu_op, fp_alu_a, fp_alu_b);

  alu_arbiter #(.RR_EN(1'b1)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(rr_req0_ready), .req1_ready(rr_req1_ready),
    .req0_op(req0_op), .req1_op(req1_op),
    .req0_a(req0_a), .req1_a(req1_a), .req0_b(req0_b), .req1_b(req1_b),
    .rsp0_valid(rr_rsp0_valid), .rsp1_valid(rr_rsp1_valid),
    .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
    .rsp0_result(rr_rsp0_result), .rsp1_result(rr_rsp1_result),
    .alu_op_o(rr_alu_op), .alu_a_o(rr_alu_a), .alu_b_o(rr_alu_b),
    .alu_result_i(rr_alu_result), .busy_o(rr_busy)
  );

  alu_arbiter #(.RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(fp_req0_ready), .req1_ready(fp_req1_ready),
    .req0_op(req0_op), .req1_op(req1_op),
    .req0_a(req0_a), .req1_a(req1_a), .req0_b(req0_b), .req1_b(req1_b),
    .rsp0_valid(fp_rsp0_valid), .rsp1_valid(fp_rsp1_valid),
    .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
    .rsp0_result(fp_rsp0_result), .rsp1_result(fp_rsp1_result),
    .alu_op_o(fp_alu_op), .alu_a_o(fp_alu_a), .alu_b_o(fp_alu_b),
    .alu_result_i(fp_alu_result), .busy_o(fp_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so a stuck run still terminates.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard for the round-robin instance: push on accept, pop on response.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (rr_req0_ready && req0_valid) begin
        exp_q.push_back('{1'b0, alu_model(req0_op, req0_a, req0_b)});
      end else if (rr_req1_ready && req1_valid) begin
        exp_q.push_back('{1'b1, alu_model(req1_op, req1_a, req1_b)});
      end
      if ((rr_rsp0_valid && rsp0_ready) || (rr_rsp1_valid && rsp1_ready)) begin
        if (exp_q.size() == 0) begin
          checkOutput("sb_unexpected_rsp", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("sb_port", {31'd0, rr_rsp1_valid}, {31'd0, e.port});
          checkOutput("sb_result", rr_rsp1_valid ? rr_rsp1_result : rr_rsp0_result, e.result);
        end
      end
    end
  end

  // Drive one request onto its port and check the accept-cycle outputs.
  task automatic applyStimulus(input vec_t v);
    tick();
    if (v.port) begin
      req1_valid = 1'b1; req1_op = AluControl'(v.op); req1_a = v.a; req1_b = v.b;
    end else begin
      req0_valid = 1'b1; req0_op = AluControl'(v.op); req0_a = v.a; req0_b = v.b;
    end
    #1;
    checkOutput("accept_ready", {31'd0, v.port ? rr_req1_ready : rr_req0_ready}, 32'd1);
    checkOutput("accept_other_ready", {31'd0, v.port ? rr_req0_ready : rr_req1_ready}, 32'd0);
    checkOutput("accept_busy", {31'd0, rr_busy}, 32'd0);
  endtask

  task automatic runVector(input vec_t v);
    applyStimulus(v);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    checkOutput("exec_busy", {31'd0, rr_busy}, 32'd1);
    checkOutput("exec_alu_op", {28'd0, rr_alu_op}, {28'd0, v.op});
    checkOutput("exec_alu_a", rr_alu_a, v.a);
    checkOutput("exec_alu_b", rr_alu_b, v.b);
    checkOutput("exec_rsp_valid", {31'd0, rr_rsp0_valid | rr_rsp1_valid}, 32'd0);
    tick();
    checkOutput("resp_owner_valid", {31'd0, v.port ? rr_rsp1_valid : rr_rsp0_valid}, 32'd1);
    checkOutput("resp_other_valid", {31'd0, v.port ? rr_rsp0_valid : rr_rsp1_valid}, 32'd0);
    checkOutput("resp_result", v.port ? rr_rsp1_result : rr_rsp0_result, v.exp_result);
    checkOutput("resp_ready_low", {31'd0, rr_req0_ready | rr_req1_ready}, 32'd0);
    tick();
    checkOutput("retire_busy", {31'd0, rr_busy}, 32'd0);
    checkOutput("retire_rsp_valid", {31'd0, rr_rsp0_valid | rr_rsp1_valid}, 32'd0);
  endtask

  initial begin
    logic exp_order[4];
    logic granted;
    int   waited;

    checks = 0;
    errors = 0;
    vecs[0] = '{1'b0, 4'h0, 32'd5,         32'd7,         32'd12};
    vecs[1] = '{1'b1, 4'h1, 32'd10,        32'd3,         32'd7};
    vecs[2] = '{1'b0, 4'h2, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000};
    vecs[3] = '{1'b1, 4'h3, 32'h0000_1200, 32'h0000_0034, 32'h0000_1234};
    vecs[4] = '{1'b0, 4'h4, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF};
    vecs[5] = '{1'b0, 4'h5, 32'hFFFF_FFFF, 32'd1,         32'd1};
    vecs[6] = '{1'b1, 4'h6, 32'd1,         32'd4,         32'd16};
    vecs[7] = '{1'b0, 4'h0, 32'h7FFF_FFFF, 32'd1,         32'h8000_0000};
    vecs[8] = '{1'b1, 4'hF, 32'd1,         32'd2,         32'hDEAD_BEEF};
    exp_order[0] = 1'b0; exp_order[1] = 1'b1; exp_order[2] = 1'b0; exp_order[3] = 1'b1;

    // Reset with both requesters asserting valid: nothing may look ready.
    rst_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_op = ALU_SUB; req1_op = ALU_XOR;
    req0_a = 32'd1; req0_b = 32'd2; req1_a = 32'd3; req1_b = 32'd4;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    #2;
    checkOutput("rst_req0_ready", {31'd0, rr_req0_ready}, 32'd0);
    checkOutput("rst_req1_ready", {31'd0, rr_req1_ready}, 32'd0);
    checkOutput("rst_rsp_valid", {31'd0, rr_rsp0_valid | rr_rsp1_valid}, 32'd0);
    checkOutput("rst_busy", {31'd0, rr_busy}, 32'd0);
    checkOutput("rst_alu_op", {28'd0, rr_alu_op}, 32'd0);
    checkOutput("rst_alu_a", rr_alu_a, 32'd0);
    checkOutput("rst_alu_b", rr_alu_b, 32'd0);
    checkOutput("rst_result", rr_rsp0_result, 32'd0);
    tick();
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst_n = 1'b1;
    $display("[TB] reset released, running single-request table");

    for (int i = 0; i < 9; i++) begin
      runVector(vecs[i]);
    end

    // Continuous contention: round-robin alternates, fixed priority keeps port 0.
    $display("[TB] contention");
    tick();
    req0_valid = 1'b1; req0_op = ALU_SUB; req0_a = 32'd10;   req0_b = 32'd3;
    req1_valid = 1'b1; req1_op = ALU_XOR; req1_a = 32'hF0;   req1_b = 32'h0F;
    #1;
    for (int i = 0; i < 4; i++) begin
      waited = 0;
      while (!(rr_req0_ready || rr_req1_ready) && waited < 10) begin
        tick();
        waited++;
      end
      if (waited >= 10) checkOutput("contention_wait_ready", 32'd0, 32'd1);
      granted = rr_req1_ready;
      checkOutput("rr_grant_order", {31'd0, granted}, {31'd0, exp_order[i]});
      checkOutput("rr_one_ready", {31'd0, rr_req0_ready & rr_req1_ready}, 32'd0);
      checkOutput("fp_grant_port0", {31'd0, fp_req0_ready}, 32'd1);
      checkOutput("fp_req1_ready", {31'd0, fp_req1_ready}, 32'd0);
      tick();
      checkOutput("fp_req1_ready_exec", {31'd0, fp_req1_ready}, 32'd0);
      tick();
      checkOutput("rr_contention_result", granted ? rr_rsp1_result : rr_rsp0_result,
                  granted ? 32'h0000_00FF : 32'd7);
      checkOutput("fp_contention_valid", {31'd0, fp_rsp0_valid}, 32'd1);
      checkOutput("fp_contention_result", fp_rsp0_result, 32'd7);
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Backpressure on requester 1 while requester 0 waits and pulses stray ready.
    $display("[TB] backpressure");
    tick();
    req1_valid = 1'b1; req1_op = ALU_OR; req1_a = 32'h1200; req1_b = 32'h0034;
    rsp1_ready = 1'b0; rsp0_ready = 1'b1;
    #1;
    checkOutput("bp_accept_req1", {31'd0, rr_req1_ready}, 32'd1);
    tick();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_op = ALU_ADD; req0_a = 32'd1; req0_b = 32'd1;
    #1;
    checkOutput("bp_exec_req0_ready", {31'd0, rr_req0_ready}, 32'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_rsp1_valid", {31'd0, rr_rsp1_valid}, 32'd1);
      checkOutput("bp_rsp1_result", rr_rsp1_result, 32'h0000_1234);
      checkOutput("bp_busy", {31'd0, rr_busy}, 32'd1);
      checkOutput("bp_req0_ready", {31'd0, rr_req0_ready}, 32'd0);
      checkOutput("bp_rsp0_valid", {31'd0, rr_rsp0_valid}, 32'd0);
      tick();
    end
    rsp1_ready = 1'b1;
    tick();
    checkOutput("bp_release_req0_ready", {31'd0, rr_req0_ready}, 32'd1);
    checkOutput("bp_release_busy", {31'd0, rr_busy}, 32'd0);
    tick();
    req0_valid = 1'b0;
    tick();
    checkOutput("bp_followup_valid", {31'd0, rr_rsp0_valid}, 32'd1);
    checkOutput("bp_followup_result", rr_rsp0_result, 32'd2);
    tick();

    // Reset pulsed during EXEC discards the transaction.
    $display("[TB] reset mid-operation");
    tick();
    req0_valid = 1'b1; req0_op = ALU_ADD; req0_a = 32'd3; req0_b = 32'd4;
    #1;
    checkOutput("mid_accept", {31'd0, rr_req0_ready}, 32'd1);
    tick();
    req0_valid = 1'b0;
    #1;
    checkOutput("mid_in_exec", {31'd0, rr_busy}, 32'd1);
    rst_n = 1'b0;
    req1_valid = 1'b1;
    #1;
    checkOutput("mid_rst_busy", {31'd0, rr_busy}, 32'd0);
    checkOutput("mid_rst_rsp_valid", {31'd0, rr_rsp0_valid | rr_rsp1_valid}, 32'd0);
    checkOutput("mid_rst_req1_ready", {31'd0, rr_req1_ready}, 32'd0);
    checkOutput("mid_rst_alu_op", {28'd0, rr_alu_op}, 32'd0);
    checkOutput("mid_rst_alu_a", rr_alu_a, 32'd0);
    checkOutput("mid_rst_alu_b", rr_alu_b, 32'd0);
    req1_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("post_rst_no_rsp", {31'd0, rr_rsp0_valid | rr_rsp1_valid}, 32'd0);
      checkOutput("post_rst_idle", {31'd0, rr_busy}, 32'd0);
    end

    tick();
    checkOutput("sb_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
